muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand/result width (even, 8 to 64).
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset_ni, input, 1, reset; asynchronous assert, active-low.
REQ-004 The block SHALL have port valid_i, input, 1, request valid.
REQ-005 The block SHALL have port ready_o, output, 1, unit can accept a request.
REQ-006 The block SHALL have port op_i, input, 3, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 The block SHALL have ports a_i and b_i, input, XLEN, rs1 and rs2 operands.
REQ-008 The block SHALL have port flush_i, input, 1, pipeline flush that aborts the in-flight operation.
REQ-009 The block SHALL have port valid_o, output, 1, result valid.
REQ-010 The block SHALL have port ready_i, input, 1, consumer accepts the result.
REQ-011 The block SHALL have port result_o, output, XLEN, registered result.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE; ready_o SHALL be 1 exactly in IDLE, and valid_o SHALL be 1 exactly in DONE.
REQ-013 Accept SHALL occur when valid_i=1 and ready_o=1: a_i, b_i and op_i are captured, and later input changes SHALL have no effect.
REQ-014 Multiply, and divide with a non-special divisor, SHALL go IDLE->CALC on accept, spend exactly XLEN cycles in CALC (radix-2, one bit per cycle, down-counter of width clog2(XLEN)+1), then enter DONE; valid_o rises XLEN+1 cycles after the accept edge.
REQ-015 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-016 DIV and REM SHALL round the quotient toward zero, the remainder SHALL take the sign of the dividend, and DIVU and REMU SHALL be unsigned.
REQ-017 Divisor 0 SHALL bypass CALC (IDLE->DONE, valid_o one cycle after accept): the quotient SHALL be all ones and the remainder SHALL be the dividend.
REQ-018 Signed overflow (dividend = most-negative, divisor = -1, DIV/REM) SHALL bypass CALC with one-cycle latency: the quotient SHALL be the most-negative value and the remainder SHALL be 0.
REQ-019 In DONE, result_o and valid_o SHALL hold stable while ready_i=0, and the FSM SHALL go DONE->IDLE on the edge where ready_i=1.
REQ-020 Back-to-back issue SHALL NOT be possible: ready_o SHALL be 0 in DONE even while ready_i=1, and the next accept SHALL occur no earlier than the cycle after handshake.
REQ-021 flush_i=1 in any state SHALL force IDLE on the next edge and discard the result (valid_o SHALL be 0 in the following cycle).
REQ-022 flush_i SHALL have priority over accept and over the DONE handshake in the same cycle.
REQ-023 result_o SHALL change only on entry to DONE.

Reset
REQ-024 While reset_ni=0 the block SHALL hold state=IDLE, valid_o=0, result_o=0, counter=0 and internal operand registers=0; ready_o SHALL be 1.
REQ-025 Reset asserted mid-CALC SHALL abort immediately (asynchronously), and no stale result SHALL appear after release.
REQ-026 The first accept SHALL be possible on the first rising edge after reset_ni deasserts.

Configuration
REQ-027 Macro MULDIV_DIV_EN defined: all eight ops SHALL be implemented as above.
REQ-028 Macro MULDIV_DIV_EN undefined: divider datapath SHALL be absent; ops 1xx SHALL still be accepted, SHALL bypass CALC, and SHALL return result_o=0 with valid_o one cycle after accept; multiply ops SHALL be unchanged.

Verification (XLEN=32)
REQ-029 MUL a=7, b=0xFFFFFFFD -> result_o=0xFFFFFFEB, valid_o rises 33 cycles after accept.
REQ-030 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each with 1-cycle latency.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, 1-cycle latency.
REQ-033 MUL accepted, ready_i held 0 for 5 cycles in DONE -> result_o/valid_o stable, ready_o=0; ready_i=1 -> IDLE, ready_o=1 next cycle.
REQ-034 flush_i pulsed 10 cycles into CALC (and separately reset_ni pulsed low mid-CALC) -> valid_o never asserts for that op, ready_o=1 next cycle, and a following MUL 3*5 returns 15.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle, valid/ready on both sides.
// Divider datapath is present only when MULDIV_DIV_EN is defined; otherwise ops 1xx return 0.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN) + 1;
`ifdef MULDIV_DIV_EN
  localparam int OW = 3;
`else
  localparam int OW = 2;
`endif
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [OW-1:0] op;
  logic [XLEN-1:0] hi, lo, mcand, result;
  logic neg_q;
  logic accept, last, bypass, a_sgn, b_sgn;
  logic [XLEN-1:0] bypass_res, a_abs, b_abs, hi_n, lo_n, calc_res;
  logic [XLEN:0] sum;
  logic [2*XLEN-1:0] prod;
`ifdef MULDIV_DIV_EN
  logic neg_r, take, div_zero, ovf;
  logic [XLEN:0] diff;
  logic [XLEN-1:0] quo, rem;
`endif
  assign ready_o  = state == IDLE;
  assign valid_o  = state == DONE;
  assign result_o = result;
  assign accept   = valid_i & ready_o & ~flush_i;
  assign last     = state == CALC && cnt == CW'(1);
  always_comb begin
    a_sgn = op_i == 3'b001 || op_i == 3'b010 || (op_i[2] && !op_i[0]);
    b_sgn = op_i == 3'b001 || (op_i[2] && !op_i[0]);
    a_abs = (a_sgn && a_i[XLEN-1]) ? -a_i : a_i;
    b_abs = (b_sgn && b_i[XLEN-1]) ? -b_i : b_i;
    // multiply step: conditional add of multiplicand into the high half, then shift right
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
`ifdef MULDIV_DIV_EN
    // restoring divide step: shift remainder left, keep the trial subtraction if non-negative
    diff = {hi, lo[XLEN-1]} - {1'b0, mcand};
    take = ~diff[XLEN];
    hi_n = op[2] ? (take ? diff[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]}) : sum[XLEN:1];
    lo_n = op[2] ? {lo[XLEN-2:0], take} : {sum[0], lo[XLEN-1:1]};
    quo = neg_q ? -lo_n : lo_n;
    rem = neg_r ? -hi_n : hi_n;
    div_zero = op_i[2] && b_i == '0;
    ovf = op_i[2] && !op_i[0] && a_i == MIN && b_i == '1;
    bypass = div_zero | ovf;
    bypass_res = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : MIN);
`else
    hi_n = sum[XLEN:1];
    lo_n = {sum[0], lo[XLEN-1:1]};
    bypass = op_i[2];
    bypass_res = '0;
`endif
    prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    calc_res = op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    calc_res = op[2] ? (op[1] ? rem : quo) : calc_res;
`endif
  end
  always_comb begin
    state_d = state;
    state_d = flush_i ? IDLE :
              accept ? (bypass ? DONE : CALC) :
              last ? DONE :
              (state == DONE && ready_i) ? IDLE : state;
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      op     <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r  <= 1'b0;
`endif
      cnt    <= '0;
      result <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (accept) begin
      op    <= op_i[OW-1:0];
      hi    <= '0;
      lo    <= op_i[2] ? a_abs : b_abs;
      mcand <= op_i[2] ? b_abs : a_abs;
      neg_q <= (a_sgn & a_i[XLEN-1]) ^ (b_sgn & b_i[XLEN-1]);
`ifdef MULDIV_DIV_EN
      neg_r <= a_sgn & a_i[XLEN-1];
`endif
      cnt   <= bypass ? '0 : CW'(XLEN);
      if (bypass) result <= bypass_res;
    end else if (state == CALC) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CW'(1);
      if (last) result <= calc_res;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: latency/arithmetic reference model with per-cycle compare plus literal vectors.
module tb_muldiv_unit;
  logic clk_i = 0, reset_ni = 0, valid_i = 0, flush_i = 0, ready_i = 0;
  logic [2:0] op_i = 0;
  logic [31:0] a_i = 0, b_i = 0;
  logic ready_o, valid_o;
  logic [31:0] result_o;
  int compared = 0, mismatched = 0;
  int m_st = 0, m_cnt = 0;
  logic [31:0] m_res = 0, m_pend = 0;
`ifdef MULDIV_DIV_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
  );

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int si, sj;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    si = a;
    sj = b;
    r = 0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      default: begin
        if (!DE) r = 0;
        else if (b == 0) r = op[1] ? a : 32'hFFFFFFFF;
        else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) r = op[1] ? 32'h0 : 32'h80000000;
        else if (op == 3'd4) r = 32'(si / sj);
        else if (op == 3'd5) r = a / b;
        else if (op == 3'd6) r = 32'(si % sj);
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 33;
    if (!DE || b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    return 33;
  endfunction

  always @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      m_st = 0;
      m_res = 0;
    end else if (flush_i) m_st = 0;
    else if (m_st == 0) begin
      if (valid_i) begin
        if (ref_lat(op_i, a_i, b_i) == 1) begin
          m_st = 2;
          m_res = ref_res(op_i, a_i, b_i);
        end else begin
          m_st = 1;
          m_cnt = 32;
          m_pend = ref_res(op_i, a_i, b_i);
        end
      end
    end else if (m_st == 1) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_st = 2;
        m_res = m_pend;
      end
    end else if (ready_i) m_st = 0;

  always @(negedge clk_i) begin
    compared++;
    if ({ready_o, valid_o, result_o} !== {m_st == 0, m_st == 2, m_res}) begin
      mismatched++;
      $display("FAIL cycle t=%0t rdy/vld/res got %b/%b/%h exp %b/%b/%h",
               $time, ready_o, valid_o, result_o, m_st == 0, m_st == 2, m_res);
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    reset_ni = 1;
    op_i = op; a_i = a; b_i = b; valid_i = 1;
    @(negedge clk_i);
    valid_i = 0;
    a_i = $urandom; b_i = $urandom; op_i = 3'($urandom);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit lit, input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    start_op(op, a, b);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    if (lit) begin
      check($sformatf("lat op%0d", op), 64'(lat), 64'(exp_lat));
      check($sformatf("res op%0d", op), 64'(result_o), 64'(exp));
    end else check($sformatf("lat op%0d", op), 64'(lat), 64'(ref_lat(op, a, b)));
    repeat (hold) @(negedge clk_i);
    ready_i = 1;
    @(negedge clk_i);
    ready_i = 0;
    check("idle after handshake rdy/vld", {ready_o, valid_o}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    mismatched++;
    $display("FAIL watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk_i);
    check("in reset rdy/vld/res", {ready_o, valid_o, result_o}, {2'b10, 32'h0});
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFEB, 33, 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 33, 0);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 33, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 33, 1);
    run_op(3'd0, 32'd3, 32'd5, 1, 32'd15, 33, 5);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1, DE ? 32'hFFFFFFFD : 32'h0, DE ? 33 : 1, 0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 1, DE ? 32'hFFFFFFFF : 32'h0, DE ? 33 : 1, 0);
    run_op(3'd5, 32'd100, 32'd0, 1, DE ? 32'hFFFFFFFF : 32'h0, 1, 2);
    run_op(3'd7, 32'd100, 32'd0, 1, DE ? 32'd100 : 32'h0, 1, 0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1, DE ? 32'h80000000 : 32'h0, 1, 0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 1, 0);
    run_op(3'd5, 32'd100, 32'd7, 1, DE ? 32'd14 : 32'h0, DE ? 33 : 1, 0);
    run_op(3'd7, 32'd100, 32'd7, 1, DE ? 32'd2 : 32'h0, DE ? 33 : 1, 0);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'h0 : $urandom;
      run_op(3'($urandom), ra, rb, 0, 32'h0, 0, $urandom_range(0, 2));
    end
    start_op(3'd0, 32'd9, 32'd9);
    repeat (9) @(negedge clk_i);
    flush_i = 1;
    @(negedge clk_i);
    flush_i = 0;
    check("flush in calc rdy/vld", {ready_o, valid_o}, 2'b10);
    repeat (40) @(negedge clk_i);
    run_op(3'd0, 32'd3, 32'd5, 1, 32'd15, 33, 0);
    start_op(3'd0, 32'd11, 32'd13);
    repeat (9) @(negedge clk_i);
    #2 reset_ni = 0;
    #1 check("async reset rdy/vld/res", {ready_o, valid_o, result_o}, {2'b10, 32'h0});
    repeat (3) @(negedge clk_i);
    run_op(3'd0, 32'd3, 32'd5, 1, 32'd15, 33, 0);
    repeat (3) @(negedge clk_i);
    start_op(3'd5, 32'd100, 32'd0);
    flush_i = 1;
    ready_i = 1;
    @(negedge clk_i);
    flush_i = 0;
    ready_i = 0;
    check("flush in done rdy/vld", {ready_o, valid_o}, 2'b10);
    op_i = 3'd0; a_i = 32'd2; b_i = 32'd2; valid_i = 1; flush_i = 1;
    @(negedge clk_i);
    valid_i = 0;
    flush_i = 0;
    check("flush beats accept rdy/vld", {ready_o, valid_o}, 2'b10);
    run_op(3'd1, 32'h80000000, 32'h80000000, 1, 32'h40000000, 33, 0);
    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
